// File: rtl/rf_sequencer.sv
// Register-file sequencer: zero-clears the file after reset, passes core accesses through, streams a full dump on request.
// Optional reset-time clear is enabled by defining RF_SEQ_CLEAR_EN.
module rf_sequencer (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       core_regWrite,
   input  logic [2:0] core_Rs,
   input  logic [2:0] core_Rd,
   input  logic [7:0] core_writeValue,
   output logic       stall,
   input  logic       dump_req,
   output logic       dump_valid,
   input  logic       dump_ready,
   output logic [2:0] dump_idx,
   output logic [7:0] dump_data,
   output logic       dump_done,
   output logic       rf_regWrite,
   output logic [2:0] rf_Rs,
   output logic [2:0] rf_Rd,
   output logic [7:0] rf_writeValue,
   input  logic [7:0] rf_val1
);

   localparam int NREGS = 8;

   typedef enum logic [1:0] {CLEAR, RUN, DUMP} state_t;

`ifdef RF_SEQ_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = RUN;
`endif

   state_t     state, next_state;
   logic [2:0] idx, next_idx;
   logic       done_q, next_done;
   logic       last_idx;

`ifdef RF_SEQ_CLEAR_EN
   logic pend, next_pend;
`endif

   assign last_idx = (idx == 3'(NREGS - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= RESET_STATE;
         idx    <= '0;
         done_q <= 1'b0;
`ifdef RF_SEQ_CLEAR_EN
         pend   <= 1'b0;
`endif
      end else begin
         state  <= next_state;
         idx    <= next_idx;
         done_q <= next_done;
`ifdef RF_SEQ_CLEAR_EN
         pend   <= next_pend;
`endif
      end
   end

   // A dump request seen on the final clear cycle goes straight to DUMP, same as one remembered in pend.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      next_done  = 1'b0;
`ifdef RF_SEQ_CLEAR_EN
      next_pend  = pend;
`endif
      case (state)
         CLEAR: begin
`ifdef RF_SEQ_CLEAR_EN
            next_idx = idx + 3'd1;
            if (dump_req)
               next_pend = 1'b1;
            if (last_idx) begin
               if (pend || dump_req) begin
                  next_state = DUMP;
                  next_pend  = 1'b0;
               end else begin
                  next_state = RUN;
               end
            end
`else
            next_state = RUN;
`endif
         end
         RUN: begin
            if (dump_req) begin
               next_state = DUMP;
               next_idx   = '0;
            end
         end
         DUMP: begin
            if (dump_ready) begin
               next_idx = idx + 3'd1;
               if (last_idx) begin
                  next_state = RUN;
                  next_done  = 1'b1;
               end
            end
         end
         default: next_state = RESET_STATE;
      endcase
   end

   // Core path is purely combinational in RUN; write enable is held off while RESET is asserted.
   always_comb begin
      rf_regWrite   = 1'b0;
      rf_Rs         = core_Rs;
      rf_Rd         = core_Rd;
      rf_writeValue = core_writeValue;
      stall         = 1'b1;
      dump_valid    = 1'b0;
      case (state)
         CLEAR: begin
            rf_regWrite   = ~RESET;
            rf_Rd         = idx;
            rf_writeValue = '0;
         end
         RUN: begin
            rf_regWrite = core_regWrite & ~RESET;
            stall       = 1'b0;
         end
         DUMP: begin
            rf_Rs      = idx;
            rf_Rd      = idx;
            dump_valid = 1'b1;
         end
         default: begin
            rf_regWrite = 1'b0;
         end
      endcase
   end

   assign dump_idx  = idx;
   assign dump_data = rf_val1;
   assign dump_done = done_q;

endmodule
